// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- multi-cycle integer ALU with an iterative shifter.
//
// Single-cycle ops (ADD/SUB, SLT, SLTU, XOR, OR, AND) complete on the accept
// edge. Shifts walk through SHIFT, moving up to SHIFT_STEP bits per edge.
// All state updates on the falling edge of i_clk_n; reset is asynchronous
// and active-low.
//
// Optional feature macro: ALU_MC_ROT_EN
//   When defined, funct7=0110000 with funct3 001/101 selects ROL/ROR on the
//   same iterative shifter. When undefined those encodings decode as SLL/SRL.
//
// Parameters:
//   XLEN        datapath width (32 or 64)
//   SHIFT_STEP  bits shifted per cycle, power of two, 1..XLEN
// Ports:
//   i_clk_n      clock, falling-edge active
//   i_rst_n      asynchronous active-low reset
//   i_valid      request strobe, accepted while o_ready=1
//   o_ready      high in IDLE only
//   i_in_a       operand A
//   i_in_b       operand B / immediate (low log2(XLEN) bits = shift amount)
//   i_funct3     operation select
//   i_funct7     operation modifier
//   i_alu_imm    1 = immediate-form instruction (suppresses SUB)
//   i_kill       synchronous abort, returns to IDLE on the next edge
//   o_valid      high in DONE only
//   i_out_ready  consumer takes the result
//   o_result     registered result
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic            i_clk_n,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_in_a,
    input  logic [XLEN-1:0] i_in_b,
    input  logic [2:0]      i_funct3,
    input  logic [6:0]      i_funct7,
    input  logic            i_alu_imm,
    input  logic            i_kill,
    output logic            o_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_result
);
    localparam int SW = $clog2(XLEN);
    // Widened by one bit so SHIFT_STEP==XLEN and XLEN itself are representable.
    localparam logic [SW:0] STEP_W = SHIFT_STEP[SW:0];
`ifdef ALU_MC_ROT_EN
    localparam logic [SW:0] XLEN_W = XLEN[SW:0];
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    typedef enum logic [2:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
`ifdef ALU_MC_ROT_EN
        ,
        SH_ROL,
        SH_ROR
`endif
    } shop_t;

    state_t          r_state, w_state_next;
    shop_t           r_shop, w_shop_next;
    logic [XLEN-1:0] r_result, w_result_next;
    logic [SW-1:0]   r_remaining, w_remaining_next;

    logic            w_alt;
    logic [SW-1:0]   w_s;
    logic [XLEN-1:0] w_alu;
    logic [SW:0]     w_rem_ext;
    logic [SW:0]     w_step;
    logic            w_last;
    logic [XLEN-1:0] w_shifted;
`ifdef ALU_MC_ROT_EN
    logic            w_rot;
`endif

    assign o_ready  = (r_state == IDLE);
    assign o_valid  = (r_state == DONE);
    assign o_result = r_result;

    assign w_alt = (i_funct7[6:1] == 6'b010000);
    assign w_s   = i_in_b[SW-1:0];
`ifdef ALU_MC_ROT_EN
    assign w_rot = (i_funct7 == 7'b0110000);
`endif

    // Single-cycle result, evaluated straight from the request inputs.
    always_comb begin
        w_alu = '0;
        case (i_funct3)
            3'b000:  w_alu = (w_alt && !i_alu_imm) ? (i_in_a - i_in_b) : (i_in_a + i_in_b);
            3'b010:  w_alu = {{(XLEN-1){1'b0}}, ($signed(i_in_a) < $signed(i_in_b))};
            3'b011:  w_alu = {{(XLEN-1){1'b0}}, (i_in_a < i_in_b)};
            3'b100:  w_alu = i_in_a ^ i_in_b;
            3'b110:  w_alu = i_in_a | i_in_b;
            3'b111:  w_alu = i_in_a & i_in_b;
            default: w_alu = '0;
        endcase
    end

    // One shifter step of min(remaining, SHIFT_STEP) bits. In SHIFT the
    // remaining count is never zero, so rotate amounts stay inside 1..XLEN-1.
    assign w_rem_ext = {1'b0, r_remaining};
    assign w_last    = (w_rem_ext <= STEP_W);
    assign w_step    = w_last ? w_rem_ext : STEP_W;

    always_comb begin
        w_shifted = r_result;
        case (r_shop)
            SH_SLL:  w_shifted = r_result << w_step;
            SH_SRL:  w_shifted = r_result >> w_step;
            SH_SRA:  w_shifted = XLEN'($signed(r_result) >>> w_step);
`ifdef ALU_MC_ROT_EN
            SH_ROL:  w_shifted = (r_result << w_step) | (r_result >> (XLEN_W - w_step));
            SH_ROR:  w_shifted = (r_result >> w_step) | (r_result << (XLEN_W - w_step));
`endif
            default: w_shifted = r_result;
        endcase
    end

    // Next-state logic. i_kill has priority over every other transition.
    always_comb begin
        w_state_next     = r_state;
        w_result_next    = r_result;
        w_remaining_next = r_remaining;
        w_shop_next      = r_shop;
        if (i_kill) begin
            w_state_next     = IDLE;
            w_remaining_next = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        if (i_funct3 == 3'b001 || i_funct3 == 3'b101) begin
                            if (i_funct3 == 3'b001) begin
                                w_shop_next = SH_SLL;
`ifdef ALU_MC_ROT_EN
                                if (w_rot) w_shop_next = SH_ROL;
`endif
                            end else begin
                                w_shop_next = w_alt ? SH_SRA : SH_SRL;
`ifdef ALU_MC_ROT_EN
                                if (w_rot) w_shop_next = SH_ROR;
`endif
                            end
                            w_result_next    = i_in_a;
                            w_remaining_next = w_s;
                            w_state_next     = (w_s == '0) ? DONE : SHIFT;
                        end else begin
                            w_result_next = w_alu;
                            w_state_next  = DONE;
                        end
                    end
                end
                SHIFT: begin
                    w_result_next    = w_shifted;
                    w_remaining_next = r_remaining - w_step[SW-1:0];
                    if (w_last) w_state_next = DONE;
                end
                DONE: begin
                    if (i_out_ready) w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(negedge i_clk_n or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_result    <= '0;
            r_remaining <= '0;
            r_shop      <= SH_SLL;
        end else begin
            r_state     <= w_state_next;
            r_result    <= w_result_next;
            r_remaining <= w_remaining_next;
            r_shop      <= w_shop_next;
        end
    end
endmodule
